mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the unified memory port around mem_arbiter.
// slave is the arbiter's view; master is the environment (requesters plus memory).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_we;

    logic              ext_req;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_we;

    logic              core_gnt;
    logic              ext_gnt;
    logic              core_rvalid;
    logic              ext_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        owner;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  core_req, core_addr, core_wdata, core_we,
        input  ext_req, ext_addr, ext_wdata, ext_we,
        input  mem_rd,
        output core_gnt, ext_gnt, core_rvalid, ext_rvalid, rdata, owner,
        output mem_addr, mem_wd, mem_we
    );

    modport master (
        output core_req, core_addr, core_wdata, core_we,
        output ext_req, ext_addr, ext_wdata, ext_we,
        output mem_rd,
        input  core_gnt, ext_gnt, core_rvalid, ext_rvalid, rdata, owner,
        input  mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (core vs external loader) for a single combinational-read memory.
// Alternates on ties, bounds bursts only while the other side waits, registers read data.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CORE = 2'b01,
        ST_EXT  = 2'b10
    } state_t;

    state_t            state;
    logic              last_ext;
    logic [CNT_W-1:0]  burst_cnt;
    logic              core_rvalid_q;
    logic              ext_rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              core_beat;
    logic              ext_beat;
    logic              rd_beat;
    logic [CNT_W:0]    burst_nxt;
    logic              burst_hit;
    logic              burst_room;

    assign core_beat = (state == ST_CORE) && bus.core_req;
    assign ext_beat  = (state == ST_EXT) && bus.ext_req;
    assign rd_beat   = (core_beat && !bus.core_we) || (ext_beat && !bus.ext_we);

    // Count after this beat; hit forces a handoff, room allows the count to advance
    assign burst_nxt  = {1'b0, burst_cnt} + (CNT_W+1)'(1);
    assign burst_hit  = (burst_nxt >= BURST_LIM);
    assign burst_room = (burst_nxt <= BURST_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            last_ext      <= 1'b1;
            burst_cnt     <= '0;
            core_rvalid_q <= 1'b0;
            ext_rvalid_q  <= 1'b0;
            rdata_q       <= '0;
        end else begin
            core_rvalid_q <= core_beat && !bus.core_we;
            ext_rvalid_q  <= ext_beat && !bus.ext_we;
            if (rd_beat) begin
                rdata_q <= bus.mem_rd;
            end

            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (bus.core_req && (!bus.ext_req || last_ext)) begin
                        state <= ST_CORE;
                    end else if (bus.ext_req) begin
                        state <= ST_EXT;
                    end
                end
                ST_CORE: begin
                    if (!bus.core_req || (bus.ext_req && burst_hit)) begin
                        state     <= bus.ext_req ? ST_EXT : ST_IDLE;
                        last_ext  <= 1'b0;
                        burst_cnt <= '0;
                    end else if (burst_room) begin
                        burst_cnt <= burst_nxt[CNT_W-1:0];
                    end
                end
                ST_EXT: begin
                    if (!bus.ext_req || (bus.core_req && burst_hit)) begin
                        state     <= bus.core_req ? ST_CORE : ST_IDLE;
                        last_ext  <= 1'b1;
                        burst_cnt <= '0;
                    end else if (burst_room) begin
                        burst_cnt <= burst_nxt[CNT_W-1:0];
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.core_gnt    = (state == ST_CORE);
    assign bus.ext_gnt     = (state == ST_EXT);
    assign bus.owner       = state;
    assign bus.core_rvalid = core_rvalid_q;
    assign bus.ext_rvalid  = ext_rvalid_q;
    assign bus.rdata       = rdata_q;

    // Memory port follows the owner only while it is actually issuing a beat
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        bus.mem_we   = 1'b0;
        if (core_beat) begin
            bus.mem_addr = bus.core_addr;
            bus.mem_wd   = bus.core_wdata;
            bus.mem_we   = bus.core_we;
        end else if (ext_beat) begin
            bus.mem_addr = bus.ext_addr;
            bus.mem_wd   = bus.ext_wdata;
            bus.mem_we   = bus.ext_we;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a rule-level ownership model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        if (a == AW'(32'h10)) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign bus.mem_rd = memval(bus.mem_addr);

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: who owns the memory (0 none, 1 core, 2 ext), who left last, beats used
    int              m_own, m_last, m_cnt;
    logic            m_rvc, m_rve;
    logic [DW-1:0]   m_rdata;
    int              n_own, n_last, n_cnt;
    logic            own_req, oth_req, own_we;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_wd;

    always_comb begin
        own_req  = 1'b0;
        oth_req  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_wd   = '0;
        if (m_own == 1) begin
            own_req = bus.core_req; oth_req = bus.ext_req; own_we = bus.core_we;
            own_addr = bus.core_addr; own_wd = bus.core_wdata;
        end else if (m_own == 2) begin
            own_req = bus.ext_req; oth_req = bus.core_req; own_we = bus.ext_we;
            own_addr = bus.ext_addr; own_wd = bus.ext_wdata;
        end
        n_own  = m_own;
        n_last = m_last;
        n_cnt  = m_cnt;
        if (m_own == 0) begin
            if (bus.core_req && bus.ext_req) n_own = 3 - m_last;
            else if (bus.core_req)           n_own = 1;
            else if (bus.ext_req)            n_own = 2;
        end else if (!own_req) begin
            n_own = oth_req ? 3 - m_own : 0;
        end else if (oth_req && m_cnt + 1 >= MB) begin
            n_own = 3 - m_own;
        end
        if (n_own != m_own) begin
            n_cnt = 0;
            if (m_own != 0) n_last = m_own;
        end else if (own_req) begin
            n_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_own <= 0; m_last <= 2; m_cnt <= 0;
            m_rvc <= 1'b0; m_rve <= 1'b0; m_rdata <= '0;
        end else begin
            m_own  <= n_own;
            m_last <= n_last;
            m_cnt  <= n_cnt;
            m_rvc  <= (m_own == 1) && own_req && !own_we;
            m_rve  <= (m_own == 2) && own_req && !own_we;
            if (own_req && !own_we) m_rdata <= memval(own_addr);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("owner",       64'(bus.owner),       64'(m_own));
            check("core_gnt",    64'(bus.core_gnt),    64'(m_own == 1));
            check("ext_gnt",     64'(bus.ext_gnt),     64'(m_own == 2));
            check("mem_we",      64'(bus.mem_we),      64'(own_req & own_we));
            check("mem_addr",    64'(bus.mem_addr),    own_req ? 64'(own_addr) : 64'd0);
            check("mem_wd",      64'(bus.mem_wd),      own_req ? 64'(own_wd) : 64'd0);
            check("core_rvalid", 64'(bus.core_rvalid), 64'(m_rvc));
            check("ext_rvalid",  64'(bus.ext_rvalid),  64'(m_rve));
            check("rdata",       64'(bus.rdata),       64'(m_rdata));
        end
    end

    task automatic drive(input logic cr, input logic [AW-1:0] ca, input logic cwe, input logic [DW-1:0] cd,
                         input logic er, input logic [AW-1:0] ea, input logic ewe, input logic [DW-1:0] ed);
        bus.core_req = cr; bus.core_addr = ca; bus.core_we = cwe; bus.core_wdata = cd;
        bus.ext_req  = er; bus.ext_addr  = ea; bus.ext_we  = ewe; bus.ext_wdata  = ed;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    int first_ext, core_cnt, bubble, gnt_cnt;
    logic [23:0] tc, te, tcw, tew;

    initial begin
        reset = 1'b0;
        bus.core_req = 1'b0; bus.core_addr = '0; bus.core_we = 1'b0; bus.core_wdata = '0;
        bus.ext_req  = 1'b0; bus.ext_addr  = '0; bus.ext_we  = 1'b0; bus.ext_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_owner", 64'(bus.owner), 64'd0);
        check("rst_gnt", 64'({bus.core_gnt, bus.ext_gnt}), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        check("rst_rvalid", 64'({bus.core_rvalid, bus.ext_rvalid}), 64'd0);

        // Both requesting right out of reset: core wins the first tie
        reset = 1'b1;
        drive(1'b1, 32'h40, 1'b0, '0, 1'b1, 32'h80, 1'b0, '0);
        check("tie_core_gnt", 64'(bus.core_gnt), 64'd1);
        check("tie_ext_gnt", 64'(bus.ext_gnt), 64'd0);
        idle(2);

        // Core read of 0x10
        drive(1'b1, 32'h10, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        check("rd_gnt", 64'(bus.core_gnt), 64'd1);
        drive(1'b1, 32'h10, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        check("rd_rvalid", 64'(bus.core_rvalid), 64'd1);
        check("rd_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        idle(1);
        check("rd_rvalid_drop", 64'(bus.core_rvalid), 64'd0);
        check("rd_rdata_hold", 64'(bus.rdata), 64'hDEADBEEF);
        idle(1);

        // Forced handoff after MAX_BURST core beats while ext waits
        first_ext = -1; core_cnt = 0; bubble = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'(32'h300 + 4 * i), 1'b0, '0, (i >= 2), AW'(32'h400 + 4 * i), 1'b0, '0);
            if (first_ext < 0) begin
                if (bus.ext_gnt) first_ext = i;
                else if (bus.core_gnt) core_cnt++;
                else bubble++;
            end
        end
        check("burst_first_ext", 64'(first_ext), 64'd4);
        check("burst_core_beats", 64'(core_cnt), 64'd4);
        check("burst_bubble", 64'(bubble), 64'd0);
        idle(2);

        // Lone ext write of 0x55 to 0x20
        drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h20, 1'b1, 32'h55);
        check("wr_mem_we", 64'(bus.mem_we), 64'd1);
        check("wr_mem_addr", 64'(bus.mem_addr), 64'h20);
        check("wr_mem_wd", 64'(bus.mem_wd), 64'h55);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h20, 1'b1, 32'h55);
        check("wr_no_rvalid", 64'(bus.ext_rvalid), 64'd0);
        idle(1);
        check("wr_we_drop", 64'(bus.mem_we), 64'd0);
        idle(1);

        // Core alone for 8 cycles keeps the grant throughout
        gnt_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AW'(32'h500 + 4 * i), 1'b0, '0, 1'b0, '0, 1'b0, '0);
            if (bus.core_gnt && !bus.ext_gnt) gnt_cnt++;
        end
        check("solo_gnt_cycles", 64'(gnt_cnt), 64'd8);
        idle(2);

        // Tie after core was last owner goes to ext
        drive(1'b1, 32'h600, 1'b0, '0, 1'b1, 32'h700, 1'b0, '0);
        check("tie_ext_after_core", 64'(bus.ext_gnt), 64'd1);
        for (int i = 0; i < 6; i++) drive(1'b1, AW'(32'h600 + i), 1'b1, DW'(32'hA000 + i), 1'b1, AW'(32'h700 + i), 1'b0, '0);
        idle(2);

        // Mixed traffic table
        tc  = 24'b1110_0111_1011_0011_1111_0001;
        te  = 24'b0111_1100_1110_1010_1100_1110;
        tcw = 24'b0100_1000_0010_0100_1001_0010;
        tew = 24'b0010_0001_0100_1000_0110_0100;
        for (int i = 0; i < 24; i++) begin
            drive(tc[i], AW'(32'h1000 + 4 * i), tcw[i], DW'(32'hC0DE0000 + i),
                  te[i], AW'(32'h2000 + 4 * i), tew[i], DW'(32'hBEEF0000 + i));
        end
        idle(2);

        // Reset during an ext read burst drops the pending rvalid at once
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, AW'(32'h30 + 4 * i), 1'b0, '0);
        check("pre_rst_rvalid", 64'(bus.ext_rvalid), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(bus.ext_rvalid), 64'd0);
        check("rst_mid_owner", 64'(bus.owner), 64'd0);
        check("rst_mid_we", 64'(bus.mem_we), 64'd0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h3C, 1'b0, '0);
        idle(1);
        reset = 1'b1;
        drive(1'b1, 32'h44, 1'b0, '0, 1'b1, 32'h88, 1'b0, '0);
        check("post_rst_tie", 64'(bus.core_gnt), 64'd1);
        idle(3);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
